// File: rtl/fifo8x9_ctrl_if.sv
// Bundle between the FIFO requester logic and the 8x9 FIFO control sequencer.
//   master: producer/consumer side; drives wr_req, rd_req and flush, observes the rest.
//   slave : controller side; observes the requests, drives the FIFO strobes
//           (wren/WrInc, rden/RdInc, WrPtrClr/RdPtrClr), rd_valid, count and status flags.
interface fifo8x9_ctrl_if #(
    parameter int unsigned CNT_W = 4
);
    logic             wr_req;
    logic             rd_req;
    logic             flush;
    logic             wren;
    logic             WrInc;
    logic             rden;
    logic             RdInc;
    logic             WrPtrClr;
    logic             RdPtrClr;
    logic             rd_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_req, rd_req, flush,
        input  wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr, rd_valid,
        input  count, full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  wr_req, rd_req, flush,
        output wren, WrInc, rden, RdInc, WrPtrClr, RdPtrClr, rd_valid,
        output count, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/fifo8x9_ctrl.sv
// Control sequencer for an 8x9 FIFO datapath.
// Turns write/read requests into FIFO enable, pointer-increment and pointer-clear
// strobes, tracks occupancy, decodes full/empty/almost flags from the registered
// count, keeps sticky overflow/underflow, and runs the pointer-clear sequence after
// reset and on flush.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - fifo8x9_ctrl_if.slave: requests in; strobes, rd_valid, count and flags out
module fifo8x9_ctrl #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2
) (
    input logic            clk,
    input logic            rst,
    fifo8x9_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AfCnt    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AeCnt    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] OneCnt   = CNT_W'(1);

    typedef enum logic [1:0] {StClr, StActive, StFlush} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_valid_q, rd_valid_d;

    logic full, empty;
    logic wren, rden, clr;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        wren        = 1'b0;
        rden        = 1'b0;
        clr         = 1'b0;

        unique case (state_q)
            StClr: begin
                clr     = 1'b1;
                state_d = StActive;
            end
            StActive: begin
                if (bus.flush) begin
                    state_d = StFlush;
                end else begin
                    // A write into a full FIFO is fine when a read frees a slot this cycle.
                    wren = bus.wr_req & (~full | bus.rd_req);
                    rden = bus.rd_req & ~empty;
                    if (wren && !rden) begin
                        count_d = count_q + OneCnt;
                    end else if (rden && !wren) begin
                        count_d = count_q - OneCnt;
                    end
                    if (bus.wr_req && !wren) overflow_d  = 1'b1;
                    if (bus.rd_req && !rden) underflow_d = 1'b1;
                end
            end
            StFlush: begin
                clr         = 1'b1;
                count_d     = '0;
                overflow_d  = 1'b0;
                underflow_d = 1'b0;
                state_d     = bus.flush ? StFlush : StActive;
            end
            default: state_d = StClr;
        endcase

        rd_valid_d = rden;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StClr;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign bus.wren         = wren;
    assign bus.WrInc        = wren;
    assign bus.rden         = rden;
    assign bus.RdInc        = rden;
    // The reset state is CLR, but the clear strobes must stay low while rst is held.
    assign bus.WrPtrClr     = clr & ~rst;
    assign bus.RdPtrClr     = clr & ~rst;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= AfCnt);
    assign bus.almost_empty = (count_q <= AeCnt);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Self-checking bench for fifo8x9_ctrl: directed scenarios plus random traffic.
// The stimulus process predicts each cycle's outputs from an occupancy model and
// queues them; a monitor on the falling edge pops and compares.
module tb_fifo8x9_ctrl;
    logic clk;
    logic rst;

    fifo8x9_ctrl_if #(.CNT_W(4)) bus ();

    fifo8x9_ctrl #(
        .DEPTH    (8),
        .CNT_W    (4),
        .AF_LEVEL (6),
        .AE_LEVEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        int          n;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    // Reference model: occupancy as a plain integer and the sequencer phase.
    typedef enum int {PhClear, PhRun, PhFlush} phase_t;
    phase_t phase = PhClear;
    int     occ = 0;
    bit     ovf = 1'b0;
    bit     unf = 1'b0;
    bit     last_rd = 1'b0;

    function automatic logic [16:0] sample();
        return {bus.wren, bus.WrInc, bus.rden, bus.RdInc, bus.WrPtrClr, bus.RdPtrClr,
                bus.rd_valid, bus.count, bus.full, bus.empty, bus.almost_full,
                bus.almost_empty, bus.overflow, bus.underflow};
    endfunction

    task automatic step(input bit r, input bit w, input bit rd, input bit f);
        exp_t e;
        bit   aw, ar, clr;
        @(posedge clk);
        #1;
        rst        = r;
        bus.wr_req = w;
        bus.rd_req = rd;
        bus.flush  = f;
        step_no++;
        aw  = 1'b0;
        ar  = 1'b0;
        clr = 1'b0;
        if (r) begin
            occ     = 0;
            ovf     = 1'b0;
            unf     = 1'b0;
            last_rd = 1'b0;
            phase   = PhClear;
            e.v = {7'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        end else begin
            if (phase == PhClear || phase == PhFlush) begin
                clr = 1'b1;
            end else if (!f) begin
                // A slot freed by a simultaneous read lets a write into a full FIFO.
                aw = w && (occ < 8 || rd);
                ar = rd && occ > 0;
            end
            e.v = {aw, aw, ar, ar, clr, clr, last_rd, 4'(occ), occ == 8, occ == 0,
                   occ >= 6, occ <= 2, ovf, unf};
            case (phase)
                PhClear: phase = PhRun;
                PhFlush: begin
                    occ   = 0;
                    ovf   = 1'b0;
                    unf   = 1'b0;
                    phase = f ? PhFlush : PhRun;
                end
                default: begin
                    if (f) begin
                        phase = PhFlush;
                    end else begin
                        occ = occ + int'(aw) - int'(ar);
                        if (w && !aw) ovf = 1'b1;
                        if (rd && !ar) unf = 1'b1;
                    end
                end
            endcase
            last_rd = ar;
        end
        e.n = step_no;
        sb_q.push_back(e);
    endtask

    // Monitor: compares on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [16:0] a;
            e = sb_q.pop_front();
            a = sample();
            checks++;
            if (a !== e.v) begin
                errors++;
                $display("FAIL step%0d outputs {wren,WrInc,rden,RdInc,WrClr,RdClr,rdv,cnt,f,e,af,ae,ov,un}: got %b need %b",
                         e.n, a, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        bus.flush  = 1'b0;

        // Reset, then the single clear cycle.
        step(1, 0, 0, 0);
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        // Fill to full, then one write too many.
        for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
        // Simultaneous write+read while full.
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        // Drain, then an underflowing read, then write+read on empty.
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        // Up to five entries, flush, and requests during the flush cycle.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        // Held flush.
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 1, 0);
        // Four entries, a read, then reset while rd_valid is in flight.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        // Random traffic with occasional flush and reset.
        for (int i = 0; i < 500; i++) begin
            bit r, w, rd, f;
            r  = ($urandom_range(0, 99) < 2);
            f  = ($urandom_range(0, 99) < 4);
            w  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            rd = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            step(r, w, rd, f);
        end
        step(0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, need 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
